// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480@60) and the small types used by the sync generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_DISP   = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_DISP   = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned DEF_TICK_DIV = 4;

    localparam int unsigned DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned CNT_W = 10;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t x;
        cnt_t y;
    } vga_pos_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

    // Inclusive window test used for the sync pulse regions.
    function automatic logic in_range(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_sync_if.sv
// Video timing bundle driven by vga_sync and consumed by the pixel/graphics logic.
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic hsync;
    logic vsync;
    logic video_on;
    logic p_tick;
    logic frame_tick;
    cnt_t pixel_x;
    cnt_t pixel_y;

    modport master (
        output hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
    );

    modport slave (
        input hsync, vsync, video_on, p_tick, frame_tick, pixel_x, pixel_y
    );

endinterface

// File: rtl/pixel_tick_gen.sv
// Mod-TICK_DIV divider producing a one-clk pixel enable on its terminal count.
module pixel_tick_gen #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (div_q == DIV_LAST) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing: pixel/line counters, registered sync pulses and frame strobe.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_DISP   = DEF_H_DISP,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_DISP   = DEF_V_DISP,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_if.master     vga
);

    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_DISP + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISP + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic     p_tick;
    vga_pos_t pos_q;
    vga_pos_t pos_d;
    sync_t    sync_q;
    sync_t    sync_d;

    pixel_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Sync levels are computed from the next count so they line up with pixel_x/pixel_y.
    always_comb begin
        pos_d = pos_q;
        if (p_tick) begin
            if (pos_q.x == CNT_W'(H_TOTAL - 1)) begin
                pos_d.x = '0;
                if (pos_q.y == CNT_W'(V_TOTAL - 1)) begin
                    pos_d.y = '0;
                end else begin
                    pos_d.y = pos_q.y + CNT_W'(1);
                end
            end else begin
                pos_d.x = pos_q.x + CNT_W'(1);
            end
        end
        sync_d.hsync = ~in_range(pos_d.x, CNT_W'(HS_START), CNT_W'(HS_END));
        sync_d.vsync = ~in_range(pos_d.y, CNT_W'(VS_START), CNT_W'(VS_END));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q  <= '0;
            sync_q <= '{hsync: 1'b1, vsync: 1'b1};
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
        end
    end

    assign vga.pixel_x    = pos_q.x;
    assign vga.pixel_y    = pos_q.y;
    assign vga.hsync      = sync_q.hsync;
    assign vga.vsync      = sync_q.vsync;
    assign vga.p_tick     = p_tick;
    assign vga.video_on   = (pos_q.x < CNT_W'(H_DISP)) && (pos_q.y < CNT_W'(V_DISP));
    assign vga.frame_tick = p_tick && (pos_q.x == CNT_W'(H_DISP - 1))
                                   && (pos_q.y == CNT_W'(V_DISP - 1));

endmodule

// File: tb/tb_vga_sync.sv
// Directed bench for vga_sync on a shrunken raster (15x8 pixels, 4 clks/pixel, 480-clk frame).
module tb_vga_sync;

    localparam int HD = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VD = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int TD = 4;
    localparam int HT = HD + HF + HS + HB;   // 15
    localparam int VT = VD + VF + VS + VB;   // 8
    localparam int FRAME = HT * VT * TD;     // 480 clks

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_sync_if vif ();

    vga_sync #(
        .H_DISP   (HD),
        .H_FP     (HF),
        .H_SYNC   (HS),
        .H_BP     (HB),
        .V_DISP   (VD),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB),
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .vga   (vif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x"},        32'(vif.pixel_x),    32'd0);
        chk({tag, "_y"},        32'(vif.pixel_y),    32'd0);
        chk({tag, "_hsync"},    32'(vif.hsync),      32'd1);
        chk({tag, "_vsync"},    32'(vif.vsync),      32'd1);
        chk({tag, "_p_tick"},   32'(vif.p_tick),     32'd0);
        chk({tag, "_frame"},    32'(vif.frame_tick), 32'd0);
        chk({tag, "_video_on"}, 32'(vif.video_on),   32'd1);
    endtask

    // Closed-form reference: cycle n after reset release maps to divider/pixel/line directly.
    task automatic run_check(input int cycles);
        int ft_cnt   = 0;
        int last_ft  = -1;
        int first_pt = -1;
        int hs_low   = 0;
        int hs_first = -1;
        int vs_lines = 0;
        for (int n = 0; n < cycles; n++) begin
            int div = n % TD;
            int pix = n / TD;
            int ex  = pix % HT;
            int ey  = (pix / HT) % VT;
            bit ept = (div == TD - 1);
            chk("pixel_x",    32'(vif.pixel_x),    32'(ex));
            chk("pixel_y",    32'(vif.pixel_y),    32'(ey));
            chk("p_tick",     32'(vif.p_tick),     32'(ept));
            chk("hsync",      32'(vif.hsync),      32'(!(ex >= HD + HF && ex <= HD + HF + HS - 1)));
            chk("vsync",      32'(vif.vsync),      32'(!(ey >= VD + VF && ey <= VD + VF + VS - 1)));
            chk("video_on",   32'(vif.video_on),   32'(ex < HD && ey < VD));
            chk("frame_tick", 32'(vif.frame_tick), 32'(ept && ex == HD - 1 && ey == VD - 1));

            if (first_pt < 0 && vif.p_tick === 1'b1) first_pt = n;
            if (n == TD) chk("x_after_first_tick", 32'(vif.pixel_x), 32'd1);
            if (n == HT * TD) begin
                chk("line_wrap_x", 32'(vif.pixel_x), 32'd0);
                chk("line_wrap_y", 32'(vif.pixel_y), 32'd1);
            end
            if (n == FRAME) chk("frame_wrap_y", 32'(vif.pixel_y), 32'd0);

            if (div == 0) begin
                if (ex == HD - 1 && ey == VD - 1) chk("von_last_visible", 32'(vif.video_on), 32'd1);
                if (ex == HD && ey == VD - 1)     chk("von_right_edge",   32'(vif.video_on), 32'd0);
                if (ex == 0 && ey == VD)          chk("von_bottom_edge",  32'(vif.video_on), 32'd0);
                if (ex == HT - 1 && ey == VT - 1) chk("von_last_total",   32'(vif.video_on), 32'd0);
            end

            if (vif.frame_tick === 1'b1) begin
                chk("ft_x", 32'(vif.pixel_x), 32'(HD - 1));
                chk("ft_y", 32'(vif.pixel_y), 32'(VD - 1));
                if (last_ft >= 0) chk("frame_period", 32'(n - last_ft), 32'(FRAME));
                last_ft = n;
                if (n < 3 * FRAME) ft_cnt++;
            end
            if (n < HT * TD && vif.p_tick === 1'b1 && vif.hsync === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(vif.pixel_x);
            end
            if (n < FRAME && vif.p_tick === 1'b1 && vif.pixel_x == 0 && vif.vsync === 1'b0) vs_lines++;
            @(negedge clk);
        end
        chk("first_p_tick_cycle", 32'(first_pt + 1), 32'(TD));
        chk("hsync_low_ticks",    32'(hs_low),       32'(HS));
        chk("hsync_low_start",    32'(hs_first),     32'(HD + HF));
        chk("vsync_low_lines",    32'(vs_lines),     32'(VS));
        if (cycles >= 3 * FRAME) chk("frame_ticks_3frames", 32'(ft_cnt), 32'd3);
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        reset = 1'b0;

        // Three full frames, then stop inside the sync region at pixel (11,5).
        run_check(3 * FRAME + (5 * HT + 11) * TD);
        chk("pre_rst_x",     32'(vif.pixel_x), 32'd11);
        chk("pre_rst_y",     32'(vif.pixel_y), 32'd5);
        chk("pre_rst_hsync", 32'(vif.hsync),   32'd0);
        chk("pre_rst_vsync", 32'(vif.vsync),   32'd0);

        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("mid_rst");
        reset = 1'b0;
        run_check(FRAME + 2 * TD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 Parameter H_DISP, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_DISP, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter TICK_DIV, 4, system clocks per pixel.
REQ-010 clk  input  1  system clock (100 MHz); single clock domain.
REQ-011 reset  input  1  synchronous, active-high reset.
REQ-012 hsync  output  1  horizontal sync, active-low, registered.
REQ-013 vsync  output  1  vertical sync, active-low, registered.
REQ-014 video_on  output  1  high while (pixel_x, pixel_y) is inside the visible area.
REQ-015 p_tick  output  1  one-clk pixel-enable pulse.
REQ-016 frame_tick  output  1  one-clk pulse at the last visible pixel of each frame (game-update strobe).
REQ-017 pixel_x  output  10  current horizontal count, 0..H_TOTAL-1.
REQ-018 pixel_y  output  10  current vertical count, 0..V_TOTAL-1.

Function
REQ-019 The block SHALL derive H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (525).
REQ-020 A mod-TICK_DIV divider SHALL count 0..TICK_DIV-1 every clk, and p_tick SHALL be high exactly when the divider equals TICK_DIV-1.
REQ-021 The horizontal counter SHALL advance only on p_tick and wrap from H_TOTAL-1 to 0.
REQ-022 The vertical counter SHALL advance only on p_tick with horizontal count at H_TOTAL-1, and SHALL wrap from V_TOTAL-1 to 0.
REQ-023 pixel_x and pixel_y SHALL be the registered counter values, with no added latency.
REQ-024 video_on SHALL be combinational: (pixel_x < H_DISP) && (pixel_y < V_DISP).
REQ-025 hsync SHALL be registered from the next horizontal count, low when the next count is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1] (656..751), so it aligns with pixel_x.
REQ-026 vsync SHALL be registered from the next vertical count, low when the next count is in [V_DISP+V_FP, V_DISP+V_FP+V_SYNC-1] (490..491).
REQ-027 frame_tick SHALL equal p_tick && pixel_x==H_DISP-1 && pixel_y==V_DISP-1: exactly one pulse per frame.
REQ-028 Counters SHALL hold their values on every clk where p_tick is low.
REQ-029 Frame period SHALL be exactly H_TOTAL*V_TOTAL*TICK_DIV clks (1,680,000 at defaults).

Reset
REQ-030 While reset is high at a clk edge, the divider, pixel_x and pixel_y SHALL become 0, hsync and vsync SHALL become 1, and p_tick and frame_tick SHALL be 0.
REQ-031 Reset asserted mid-frame SHALL restart timing from (0,0) with divider 0; the first p_tick SHALL occur TICK_DIV clks after reset is released.

Structure
REQ-032 H/V timing constants and the derived totals SHALL live in a shared vga_timing package, and pong graphics blocks SHALL use them.
REQ-033 The divider SHALL be a sub-module named pixel_tick_gen.
REQ-034 Total RTL SHALL remain within one file per module, with no latches.

Verification
REQ-035 Reset release: count clks to the first p_tick -> p_tick is seen 4 clks after release, and pixel_x steps 0->1 on it.
REQ-036 Line timing: run one line -> pixel_x wraps 799->0, hsync is low for exactly 96 p_ticks starting at pixel_x=656, and pixel_y increments by 1.
REQ-037 Frame timing: run one frame -> vsync is low for lines 490-491 only, pixel_y wraps 524->0, and the frame lasts 1,680,000 clks.
REQ-038 video_on: check (639,479)=1, (640,479)=0, (0,480)=0, (799,524)=0.
REQ-039 frame_tick: run 3 frames -> exactly 3 one-clk pulses, each coinciding with pixel_x=639 and pixel_y=479.
REQ-040 Mid-frame reset at (300,200) -> the next cycle shows pixel_x=0, pixel_y=0, hsync=1, vsync=1, and normal timing resumes.
